// File: rtl/rx_controller.sv
// -----------------------------------------------------------------------------
// rx_controller
// Serial receiver for the idle-high, LSB-first byte stream produced by the
// companion transmitter. The default build decodes 8N1 frames. Defining the
// macro RX_PARITY_EN adds a parity bit (8E1/8O1 frames, selected by PARITY_ODD)
// and the parity_err port.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (minimum 4)
//   PARITY_ODD    0 = even parity, 1 = odd parity (only with RX_PARITY_EN)
//
// Ports
//   CLK_50M     in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   Din         in   serial line, asynchronous to CLK_50M
//   Dout        out  last correctly received byte, held until the next good frame
//   Dout_valid  out  1-cycle pulse when Dout is updated
//   busy        out  high while a frame is being received
//   frame_err   out  1-cycle pulse when the stop bit is sampled low
//   parity_err  out  1-cycle pulse on parity mismatch (RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module rx_controller #(
    parameter int CLKS_PER_BIT = 5208
`ifdef RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       CLK_50M,
    input  logic       reset_n,
    input  logic       Din,
    output logic [7:0] Dout,
    output logic       Dout_valid,
    output logic       busy,
    output logic       frame_err
`ifdef RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Last count of the half-bit wait (start bit) and of a full bit period.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic          sync1_r;
    logic          sync2_r;
    logic          rx_s;

`ifdef RX_PARITY_EN
    logic          par_bad_r;

    // Parity bit the transmitter is expected to send for a given data byte.
    function automatic logic expected_parity(input logic [7:0] data);
        return (^data) ^ PARITY_ODD;
    endfunction
`endif

    assign rx_s = sync2_r;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= Din;
            sync2_r <= sync1_r;
        end
    end

    // Frame FSM with registered data, strobes and busy flag.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            idx_r      <= 3'd0;
            shift_r    <= 8'h00;
            Dout       <= 8'h00;
            Dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad_r  <= 1'b0;
`endif
        end else begin
            // Strobes default low so each assertion lasts exactly one cycle.
            Dout_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_r)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_r <= S_START;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject short glitches.
                    if (cnt_r == HALF_M1) begin
                        cnt_r <= {CW{1'b0}};
                        if (!rx_s) begin
                            state_r <= S_DATA;
                            idx_r   <= 3'd0;
                        end else begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r          <= {CW{1'b0}};
                        shift_r[idx_r] <= rx_s;
                        idx_r          <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_r <= S_PARITY;
`else
                            state_r <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r     <= {CW{1'b0}};
                        par_bad_r <= (rx_s != expected_parity(shift_r));
                        state_r   <= S_STOP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r <= {CW{1'b0}};
                        if (rx_s) begin
`ifdef RX_PARITY_EN
                            if (par_bad_r) begin
                                parity_err <= 1'b1;
                            end else begin
                                Dout       <= shift_r;
                                Dout_valid <= 1'b1;
                            end
`else
                            Dout       <= shift_r;
                            Dout_valid <= 1'b1;
`endif
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            // A low stop bit outranks a parity error.
                            frame_err <= 1'b1;
                            state_r   <= S_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start bit counts.
                    if (rx_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_rx_controller
// Directed bench for rx_controller with CLKS_PER_BIT=16 and a 20 ns clock.
// Frames are driven bit by bit on the falling clock edge; a monitor counts the
// output strobes and logs each received byte for later comparison.
// -----------------------------------------------------------------------------
module tb_rx_controller;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       frame_err;
`ifdef RX_PARITY_EN
    logic       parity_err;
    int         pcount = 0;
`endif
    logic       par_flip = 1'b0;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         vcount   = 0;
    int         fcount   = 0;
    logic [7:0] vlog [64];

    rx_controller #(.CLKS_PER_BIT(CPB)) dut (
        .CLK_50M    (clk),
        .reset_n    (reset_n),
        .Din        (din),
        .Dout       (dout),
        .Dout_valid (dout_valid),
        .busy       (busy),
        .frame_err  (frame_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (dout_valid) begin
            vlog[vcount % 64] <= dout;
            vcount            <= vcount + 1;
        end
        if (frame_err) begin
            fcount <= fcount + 1;
        end
`ifdef RX_PARITY_EN
        if (parity_err) begin
            pcount <= pcount + 1;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, then the given stop level.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        din = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            din = data[i];
            wait_cycles(CPB);
            if (i == 4) check("busy_mid_frame", 32'(busy), 32'd1);
        end
`ifdef RX_PARITY_EN
        din = (^data) ^ par_flip;
        wait_cycles(CPB);
`endif
        din = stop_bit;
        wait_cycles(CPB);
    endtask

    initial begin
        int         v0;
        int         f0;
        logic [7:0] pat;

        // 1: reset held while the line toggles
        reset_n = 1'b0;
        din     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = ~din;
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_valid", 32'(dout_valid), 32'd0);
        end
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        din = 1'b1;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(4);

        // 2: single good frame
        v0 = vcount; f0 = fcount;
        send_frame(8'hAC, 1'b1);
        wait_cycles(4);
        check("ac_valid_count", 32'(vcount - v0), 32'd1);
        check("ac_logged", 32'(vlog[v0 % 64]), 32'hAC);
        check("ac_dout", 32'(dout), 32'hAC);
        check("ac_frame_err", 32'(fcount - f0), 32'd0);
        check("ac_busy_after", 32'(busy), 32'd0);

        // 3: short glitch rejected
        v0 = vcount; f0 = fcount;
        din = 1'b0;
        wait_cycles(4);
        din = 1'b1;
        wait_cycles(16);
        check("glitch_valid", 32'(vcount - v0), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_frame_err", 32'(fcount - f0), 32'd0);

        // 4: framing error, held-low line, then recovery
        v0 = vcount; f0 = fcount;
        send_frame(8'h55, 1'b0);
        wait_cycles(40);
        check("brk_frame_err", 32'(fcount - f0), 32'd1);
        check("brk_valid", 32'(vcount - v0), 32'd0);
        check("brk_dout_held", 32'(dout), 32'hAC);
        check("brk_busy_held", 32'(busy), 32'd1);
        din = 1'b1;
        wait_cycles(16);
        check("brk_busy_release", 32'(busy), 32'd0);
        check("brk_no_restart", 32'(fcount - f0), 32'd1);
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        check("3c_dout", 32'(dout), 32'h3C);
        check("3c_valid_count", 32'(vcount - v0), 32'd1);

        // 5: back-to-back frames
        v0 = vcount;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(4);
        check("b2b_valid_count", 32'(vcount - v0), 32'd2);
        check("b2b_first", 32'(vlog[v0 % 64]), 32'h00);
        check("b2b_second", 32'(vlog[(v0 + 1) % 64]), 32'hFF);

        // 6: reset during data bit 4 aborts the frame
        v0  = vcount;
        pat = 8'hA5;
        din = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            din = pat[i];
            wait_cycles(CPB);
        end
        din = pat[4];
        wait_cycles(8);
        reset_n = 1'b0;
        wait_cycles(2);
        check("abort_dout", 32'(dout), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        din = 1'b1;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(20);
        check("abort_no_strobe", 32'(vcount - v0), 32'd0);
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_valid_count", 32'(vcount - v0), 32'd1);

`ifdef RX_PARITY_EN
        // Parity build: good parity accepted, bad parity flagged and Dout held
        v0 = vcount;
        f0 = pcount;
        par_flip = 1'b0;
        send_frame(8'hAC, 1'b1);
        wait_cycles(4);
        check("par_ok_dout", 32'(dout), 32'hAC);
        check("par_ok_valid", 32'(vcount - v0), 32'd1);
        par_flip = 1'b1;
        send_frame(8'h5A, 1'b1);
        wait_cycles(4);
        check("par_bad_err", 32'(pcount - f0), 32'd1);
        check("par_bad_dout", 32'(dout), 32'hAC);
        check("par_bad_valid", 32'(vcount - v0), 32'd1);
        par_flip = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
